fc_layer_param: RTL and testbench
=================================

FC_LAYER_PARAM -- requirements
Module: fc_layer_param

Interface
REQ-001 SHALL have parameter BIT, default 16, meaning element width in bits (float16 for the default).
REQ-002 SHALL have parameter N_IN, default 128, meaning number of input lanes per ROM/RAM word.
REQ-003 SHALL have parameter N_OUT, default 10, meaning number of output neurons (legal range 1..N_IN).
REQ-004 SHALL have parameter ADDR_W, default 11, meaning ROM address width.
REQ-005 SHALL have parameter ROM_BASE, default 11'h401, meaning the address of the weight row for neuron 0.
REQ-006 SHALL have parameter BIAS_BASE, default 11'h40b, meaning the address of the packed bias word.
REQ-007 SHALL have port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-008 SHALL have port iRst_n, input, 1 bit: synchronous, active-low reset.
REQ-009 SHALL have port ena, input, 1 bit: clock-enable; when low, all state and outputs hold.
REQ-010 SHALL have port start, input, 1 bit: single-cycle start request.
REQ-011 SHALL have port relu_en, input, 1 bit: runtime ReLU select, sampled with start.
REQ-012 SHALL have port data_from_rom, input, N_IN*BIT bits: weight/bias word, valid one cycle after its address.
REQ-013 SHALL have port data_from_ram, input, N_IN*BIT bits: activation vector.
REQ-014 SHALL have port data_from_mac, input, 2*BIT-1 bits: dot-product result from the shared MultAdder.
REQ-015 SHALL have port ovf_from_mac, input, 1 bit: MultAdder overflow.
REQ-016 SHALL have port busy, output, 1 bit: high from start acceptance until done.
REQ-017 SHALL have port done, output, 1 bit: level; high once all rows are written.
REQ-018 SHALL have port overflow, output, 1 bit: sticky overflow for the current run.
REQ-019 SHALL have port addr_to_rom, output, ADDR_W bits: ROM address.
REQ-020 SHALL have ports opr1_to_mac and opr2_to_mac, output, N_IN*BIT bits each: activation and weight operands.
REQ-021 SHALL have port data_to_ram, output, N_OUT*BIT bits: packed results; neuron r occupies bits [BIT*r+BIT-1 : BIT*r].

Function
REQ-022 SHALL implement states IDLE, BIAS_REQ, BIAS_GET, ROW_REQ, ROW_MUL, ROW_ADD, ROW_WB and DONE.
REQ-023 In IDLE or DONE, start=1 SHALL clear done and overflow, set busy, latch relu_en, clear the row counter and go to BIAS_REQ; start SHALL be ignored in all other states.
REQ-024 BIAS_REQ SHALL drive addr_to_rom=BIAS_BASE and go to BIAS_GET.
REQ-025 BIAS_GET SHALL latch data_from_rom into an internal bias register and go to ROW_REQ.
REQ-026 ROW_REQ SHALL drive addr_to_rom=ROM_BASE+row and go to ROW_MUL.
REQ-027 ROW_MUL SHALL drive opr1_to_mac=data_from_ram and opr2_to_mac=data_from_rom, then go to ROW_ADD.
REQ-028 ROW_ADD SHALL register data_from_mac and {bias[row], (BIT-1) zeros} into the internal Float16Adder operands, OR ovf_from_mac into overflow, and go to ROW_WB.
REQ-029 ROW_WB SHALL OR the adder overflow into overflow and write sum[2*BIT-2:BIT-1] to slice row of data_to_ram.
REQ-030 When the latched ReLU select is set in ROW_WB, a sum with sign=1 and nonzero magnitude SHALL be written as 0; -0 SHALL pass unchanged.
REQ-031 ROW_WB SHALL go to DONE if row==N_OUT-1, otherwise increment row and go to ROW_REQ; row SHALL never index beyond N_OUT-1.
REQ-032 DONE SHALL hold done=1 and busy=0 until the next start.
REQ-033 Latency SHALL be 3+4*N_OUT rising edges from the edge sampling start to done=1, plus one edge per cycle with ena=0.
REQ-034 data_to_ram SHALL retain its previous contents for rows not yet rewritten in the current run.

Reset
REQ-035 With ena=1 and iRst_n=0, the block SHALL go to IDLE and set busy=0, done=0, overflow=0, addr_to_rom=0, opr1_to_mac=0, opr2_to_mac=0, data_to_ram=0, row=0 and bias=0, including mid-run.
REQ-036 Reset SHALL take precedence over start; ena=0 SHALL block reset, which takes effect at the first edge with ena=1.

Verification
REQ-037 N_OUT=10, mac=={0x3C00, 15'b0}, all biases 0x3C00, start -> done rises at edge 43, every slice is 0x4000 (2.0), overflow=0.
REQ-038 row 2 mac={0xC400, 15'b0}, bias 0x3C00, relu_en=1 -> slice 2 is 0x0000; the same run with relu_en=0 -> slice 2 is 0xC200.
REQ-039 ovf_from_mac=1 only during ROW_ADD of row 3 -> overflow=1 at done; the next start clears it to 0.
REQ-040 ena=0 for 5 cycles during row 4 -> done rises at edge 48 and results are identical to the unstalled run.
REQ-041 iRst_n=0 during row 6 -> all outputs 0 and state IDLE next edge; a new start yields a full correct run.
REQ-042 start pulsed during row 1 and N_OUT=1 build -> the mid-run start is ignored; the N_OUT=1 build raises done at edge 7.

Source files
------------

// File: rtl/fc_layer_param.sv
// ============================================================================
// Module   : fc_layer_param
// Purpose  : Fully-connected layer sequencer: bias fetch, per-neuron MAC, bias
//            add in an extended float format, optional ReLU, packed writeback.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fc_layer_param #(
    parameter int                BIT       = 16,
    parameter int                N_IN      = 128,
    parameter int                N_OUT     = 10,
    parameter int                ADDR_W    = 11,
    parameter logic [ADDR_W-1:0] ROM_BASE  = 11'h401,
    parameter logic [ADDR_W-1:0] BIAS_BASE = 11'h40b
) (
    input  logic                  clk,
    input  logic                  iRst_n,
    input  logic                  ena,
    input  logic                  start,
    input  logic                  relu_en,
    input  logic [N_IN*BIT-1:0]   data_from_rom,
    input  logic [N_IN*BIT-1:0]   data_from_ram,
    input  logic [2*BIT-2:0]      data_from_mac,
    input  logic                  ovf_from_mac,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_W-1:0]     addr_to_rom,
    output logic [N_IN*BIT-1:0]   opr1_to_mac,
    output logic [N_IN*BIT-1:0]   opr2_to_mac,
    output logic [N_OUT*BIT-1:0]  data_to_ram
);

    // Sum format is the element format with BIT-1 extra mantissa bits.
    localparam int c_sum_w = 2*BIT - 1;
    localparam int c_exp_w = (BIT == 64) ? 11 : (BIT == 32) ? 8 : 5;
    localparam int c_man_w = c_sum_w - 1 - c_exp_w;
    localparam int c_sig_w = c_man_w + 2;
    localparam int c_lz_w  = $clog2(c_sig_w) + 1;
    localparam int c_row_w = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [c_row_w-1:0] c_last_row = c_row_w'(N_OUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_BIAS_REQ, S_BIAS_GET, S_ROW_REQ,
        S_ROW_MUL, S_ROW_ADD, S_ROW_WB, S_DONE
    } state_t;

    state_t                 r_state;
    logic                   r_busy, r_done, r_overflow, r_relu;
    logic [c_row_w-1:0]     r_row;
    logic [ADDR_W-1:0]      r_addr;
    logic [N_IN*BIT-1:0]    r_opr1, r_opr2;
    logic [N_OUT*BIT-1:0]   r_ram, r_bias;
    logic [c_sum_w-1:0]     r_add_a, r_add_b;

    logic                   w_swap, w_sub, w_add_ovf;
    logic [c_sum_w-1:0]     w_big, w_small, w_sum;
    logic [c_exp_w-1:0]     w_e_big, w_e_small, w_dexp;
    logic [c_sig_w-1:0]     w_sig_big, w_sig_small, w_sig_sh, w_raw;
    logic [c_exp_w+1:0]     w_e_res;
    logic [c_man_w-1:0]     w_norm;
    logic [c_lz_w-1:0]      w_lz;
    logic [BIT-1:0]         w_bias_row, w_slice, w_wb;

    // Order operands by magnitude so the smaller one is always the one shifted.
    assign w_swap      = r_add_b[c_sum_w-2:0] > r_add_a[c_sum_w-2:0];
    assign w_big       = w_swap ? r_add_b : r_add_a;
    assign w_small     = w_swap ? r_add_a : r_add_b;
    assign w_e_big     = w_big[c_sum_w-2 -: c_exp_w];
    assign w_e_small   = w_small[c_sum_w-2 -: c_exp_w];
    assign w_sig_big   = (w_e_big == '0)   ? '0 : {2'b01, w_big[c_man_w-1:0]};
    assign w_sig_small = (w_e_small == '0) ? '0 : {2'b01, w_small[c_man_w-1:0]};
    assign w_dexp      = w_e_big - w_e_small;
    assign w_sig_sh    = (32'(w_dexp) >= c_sig_w) ? '0 : (w_sig_small >> w_dexp);
    assign w_sub       = w_big[c_sum_w-1] ^ w_small[c_sum_w-1];
    assign w_raw       = w_sub ? (w_sig_big - w_sig_sh) : (w_sig_big + w_sig_sh);

    always_comb begin
        logic found;
        found = 1'b0;
        w_lz  = '0;
        for (int i = c_sig_w - 2; i >= 0; i--) begin
            if (!found && w_raw[i]) begin
                w_lz  = c_lz_w'(c_sig_w - 2 - i);
                found = 1'b1;
            end
        end
    end

    // Denormals flush to zero; the result is truncated, not rounded.
    always_comb begin
        logic normal;
        normal    = 1'b0;
        w_sum     = '0;
        w_add_ovf = 1'b0;
        w_e_res   = '0;
        w_norm    = '0;
        if (w_e_big == '1) begin
            w_add_ovf = 1'b1;
            w_sum     = {w_big[c_sum_w-1], {c_exp_w{1'b1}}, {c_man_w{1'b0}}};
        end else if (w_sig_big == '0) begin
            w_sum = {r_add_a[c_sum_w-1] & r_add_b[c_sum_w-1], {(c_sum_w-1){1'b0}}};
        end else if (w_raw[c_sig_w-1]) begin
            normal  = 1'b1;
            w_e_res = {2'b00, w_e_big} + 1'b1;
            w_norm  = w_raw[c_man_w:1];
        end else if (w_raw != '0 && {2'b00, w_e_big} > (c_exp_w+2)'(w_lz)) begin
            normal  = 1'b1;
            w_e_res = {2'b00, w_e_big} - (c_exp_w+2)'(w_lz);
            w_norm  = c_man_w'(w_raw << w_lz);
        end
        if (normal) begin
            if (w_e_res >= {2'b00, {c_exp_w{1'b1}}}) begin
                w_add_ovf = 1'b1;
                w_sum     = {w_big[c_sum_w-1], {c_exp_w{1'b1}}, {c_man_w{1'b0}}};
            end else begin
                w_sum = {w_big[c_sum_w-1], w_e_res[c_exp_w-1:0], w_norm};
            end
        end
    end

    assign w_bias_row = r_bias[r_row*BIT +: BIT];
    assign w_slice    = w_sum[c_sum_w-1 -: BIT];
    // ReLU zeroes negative nonzero values only; -0 is passed through.
    assign w_wb       = (r_relu && w_slice[BIT-1] && (|w_slice[BIT-2:0])) ? '0 : w_slice;

    always_ff @(posedge clk) begin
        if (ena) begin
            if (!iRst_n) begin
                r_state    <= S_IDLE;
                r_busy     <= 1'b0;
                r_done     <= 1'b0;
                r_overflow <= 1'b0;
                r_relu     <= 1'b0;
                r_row      <= '0;
                r_addr     <= '0;
                r_opr1     <= '0;
                r_opr2     <= '0;
                r_ram      <= '0;
                r_bias     <= '0;
                r_add_a    <= '0;
                r_add_b    <= '0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            r_done     <= 1'b0;
                            r_overflow <= 1'b0;
                            r_busy     <= 1'b1;
                            r_relu     <= relu_en;
                            r_row      <= '0;
                            r_addr     <= BIAS_BASE;
                            r_state    <= S_BIAS_REQ;
                        end
                    end
                    S_BIAS_REQ: r_state <= S_BIAS_GET;
                    S_BIAS_GET: begin
                        r_bias  <= data_from_rom[N_OUT*BIT-1:0];
                        r_addr  <= ROM_BASE;
                        r_state <= S_ROW_REQ;
                    end
                    S_ROW_REQ: r_state <= S_ROW_MUL;
                    S_ROW_MUL: begin
                        r_opr1  <= data_from_ram;
                        r_opr2  <= data_from_rom;
                        r_state <= S_ROW_ADD;
                    end
                    S_ROW_ADD: begin
                        r_add_a    <= data_from_mac;
                        r_add_b    <= {w_bias_row, {(BIT-1){1'b0}}};
                        r_overflow <= r_overflow | ovf_from_mac;
                        r_state    <= S_ROW_WB;
                    end
                    S_ROW_WB: begin
                        r_overflow              <= r_overflow | w_add_ovf;
                        r_ram[r_row*BIT +: BIT] <= w_wb;
                        if (r_row == c_last_row) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_row   <= r_row + 1'b1;
                            r_addr  <= ROM_BASE + ADDR_W'(r_row) + ADDR_W'(1);
                            r_state <= S_ROW_REQ;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign overflow    = r_overflow;
    assign addr_to_rom = r_addr;
    assign opr1_to_mac = r_opr1;
    assign opr2_to_mac = r_opr2;
    assign data_to_ram = r_ram;

endmodule

`default_nettype wire

// File: tb/tb_fc_layer_param.sv
// ============================================================================
// Module   : tb_fc_layer_param
// Purpose  : Directed self-checking bench for fc_layer_param (N_OUT=10 and 1).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fc_layer_param;

    localparam int BIT    = 16;
    localparam int N_IN   = 128;
    localparam int N_OUT  = 10;
    localparam int ADDR_W = 11;
    localparam logic [ADDR_W-1:0] ROM_BASE  = 11'h401;
    localparam logic [ADDR_W-1:0] BIAS_BASE = 11'h40b;
    localparam int DW = N_IN*BIT;
    localparam int SW = 2*BIT-1;

    logic clk = 1'b0;
    logic iRst_n = 1'b0, ena = 1'b1, start = 1'b0, relu_en = 1'b0;
    logic [DW-1:0] rom_q = '0, rom_q1 = '0, ram_vec, bias_word;
    logic [SW-1:0] mac_tab [N_OUT];
    logic [SW-1:0] mac, mac1;
    logic ovf, ovf_row3, ovf1;

    logic busy, done, overflow, busy1, done1, overflow1;
    logic [ADDR_W-1:0] addr, addr1;
    logic [DW-1:0] opr1, opr2, opr1_1, opr2_1;
    logic [N_OUT*BIT-1:0] ram_out;
    logic [BIT-1:0] ram_out1;

    logic [15:0] exp_s [N_OUT];
    int n_tests = 0, n_fail = 0;
    int de, de1;

    fc_layer_param #(.BIT(BIT), .N_IN(N_IN), .N_OUT(N_OUT), .ADDR_W(ADDR_W),
                     .ROM_BASE(ROM_BASE), .BIAS_BASE(BIAS_BASE)) dut (
        .clk(clk), .iRst_n(iRst_n), .ena(ena), .start(start), .relu_en(relu_en),
        .data_from_rom(rom_q), .data_from_ram(ram_vec), .data_from_mac(mac),
        .ovf_from_mac(ovf), .busy(busy), .done(done), .overflow(overflow),
        .addr_to_rom(addr), .opr1_to_mac(opr1), .opr2_to_mac(opr2),
        .data_to_ram(ram_out)
    );

    fc_layer_param #(.BIT(BIT), .N_IN(N_IN), .N_OUT(1), .ADDR_W(ADDR_W),
                     .ROM_BASE(ROM_BASE), .BIAS_BASE(BIAS_BASE)) dut1 (
        .clk(clk), .iRst_n(iRst_n), .ena(ena), .start(start), .relu_en(relu_en),
        .data_from_rom(rom_q1), .data_from_ram(ram_vec), .data_from_mac(mac1),
        .ovf_from_mac(ovf1), .busy(busy1), .done(done1), .overflow(overflow1),
        .addr_to_rom(addr1), .opr1_to_mac(opr1_1), .opr2_to_mac(opr2_1),
        .data_to_ram(ram_out1)
    );

    always #5 clk = ~clk;

    // ROM: bias word at BIAS_BASE, weight row r carries r in its low byte.
    function automatic logic [DW-1:0] rom_word(input logic [ADDR_W-1:0] a);
        logic [DW-1:0] w;
        w = '0;
        if (a == BIAS_BASE) w = bias_word;
        else                w[7:0] = 8'(a - ROM_BASE);
        return w;
    endfunction

    always @(posedge clk) begin
        rom_q  <= rom_word(addr);
        rom_q1 <= rom_word(addr1);
    end

    // MAC stand-in: result is selected by the row id carried in the weight operand.
    assign mac  = mac_tab[opr2[3:0]];
    assign mac1 = mac_tab[opr2_1[3:0]];
    assign ovf  = ovf_row3 && (opr2[7:0] == 8'd3);
    assign ovf1 = 1'b0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [N_OUT*BIT-1:0] packed_exp();
        logic [N_OUT*BIT-1:0] v;
        for (int i = 0; i < N_OUT; i++) v[i*BIT +: BIT] = exp_s[i];
        return v;
    endfunction

    task automatic run(input logic relu, input bit stall, input bit mid_start,
                       input int rst_at, input logic [15:0] prev2,
                       output int done_edge, output int done1_edge);
        done_edge  = -1;
        done1_edge = -1;
        @(negedge clk);
        relu_en = relu;
        start   = 1'b1;
        for (int n = 1; n <= 120; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                start = 1'b0;
                check("busy_after_start", 256'(busy), 256'(1'b1));
            end
            if (n == 5)  check("opr1_operand", 256'(opr1[255:0]), ram_vec[255:0]);
            if (n == 12) check("slice2_retained", 256'(ram_out[2*BIT +: BIT]), 256'(prev2));
            if (mid_start && n == 7) start = 1'b1;
            if (mid_start && n == 8) start = 1'b0;
            if (stall && n == 20) ena = 1'b0;
            if (stall && n == 25) ena = 1'b1;
            if (done1 && done1_edge < 0) done1_edge = n;
            if (done && done_edge < 0) begin
                done_edge = n;
                break;
            end
            if (rst_at > 0 && n == rst_at) iRst_n = 1'b0;
            if (rst_at > 0 && n == rst_at + 1) begin
                iRst_n = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        ram_vec = '0;
        ram_vec[63:0] = 64'hA5A5_0123_4567_89AB;
        bias_word = '0;
        for (int i = 0; i < N_OUT; i++) begin
            bias_word[i*BIT +: BIT] = 16'h3C00;
            mac_tab[i] = {16'h3C00, 15'b0};
        end
        ovf_row3 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 256'(busy), 256'(1'b0));
        check("rst_done", 256'(done), 256'(1'b0));
        check("rst_ovf", 256'(overflow), 256'(1'b0));
        check("rst_addr", 256'(addr), 256'(0));
        check("rst_opr2", opr2[255:0], 256'(0));
        check("rst_ram", 256'(ram_out), 256'(0));
        iRst_n = 1'b1;

        // 1.0 + 1.0 everywhere
        run(1'b0, 1'b0, 1'b0, 0, 16'h0000, de, de1);
        for (int i = 0; i < N_OUT; i++) exp_s[i] = 16'h4000;
        check("t1_done_edge", 256'(de), 256'(43));
        check("t1_ram", 256'(ram_out), 256'(packed_exp()));
        check("t1_ovf", 256'(overflow), 256'(1'b0));
        check("t1_busy", 256'(busy), 256'(1'b0));
        check("n1_done_edge", 256'(de1), 256'(7));
        check("n1_ram", 256'(ram_out1), 256'(16'h4000));

        // row 2: -4.0 + 1.0 under ReLU; row 5: -0 + -0
        mac_tab[2] = {16'hC400, 15'b0};
        mac_tab[5] = {16'h8000, 15'b0};
        bias_word[5*BIT +: BIT] = 16'h8000;
        run(1'b1, 1'b0, 1'b0, 0, 16'h4000, de, de1);
        exp_s[2] = 16'h0000;
        exp_s[5] = 16'h8000;
        check("t2_done_edge", 256'(de), 256'(43));
        check("t2_ram_relu", 256'(ram_out), 256'(packed_exp()));
        check("t2_ovf", 256'(overflow), 256'(1'b0));

        run(1'b0, 1'b0, 1'b0, 0, 16'h0000, de, de1);
        exp_s[2] = 16'hC200;
        check("t3_ram_norelu", 256'(ram_out), 256'(packed_exp()));

        ovf_row3 = 1'b1;
        run(1'b0, 1'b0, 1'b0, 0, 16'hC200, de, de1);
        ovf_row3 = 1'b0;
        check("t4_ovf_set", 256'(overflow), 256'(1'b1));
        check("t4_done", 256'(done), 256'(1'b1));

        // stall 5 cycles in row 4; also proves the new start cleared overflow
        run(1'b0, 1'b1, 1'b0, 0, 16'hC200, de, de1);
        check("t5_done_edge", 256'(de), 256'(48));
        check("t5_ovf_cleared", 256'(overflow), 256'(1'b0));
        check("t5_ram", 256'(ram_out), 256'(packed_exp()));

        run(1'b0, 1'b0, 1'b1, 0, 16'hC200, de, de1);
        check("t6_midstart_edge", 256'(de), 256'(43));
        check("t6_ram", 256'(ram_out), 256'(packed_exp()));

        // reset during row 6
        run(1'b0, 1'b0, 1'b0, 29, 16'hC200, de, de1);
        check("t7_no_done", 256'(de), 256'(-1));
        check("t7_busy", 256'(busy), 256'(1'b0));
        check("t7_done", 256'(done), 256'(1'b0));
        check("t7_addr", 256'(addr), 256'(0));
        check("t7_opr1", opr1[255:0], 256'(0));
        check("t7_ram", 256'(ram_out), 256'(0));
        check("t7_ram_n1", 256'(ram_out1), 256'(0));

        run(1'b1, 1'b0, 1'b0, 0, 16'h0000, de, de1);
        exp_s[2] = 16'h0000;
        check("t8_done_edge", 256'(de), 256'(43));
        check("t8_ram", 256'(ram_out), 256'(packed_exp()));
        check("t8_n1_ram", 256'(ram_out1), 256'(16'h4000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
